// File: rtl/pool_collector.sv
// pool_collector: frame buffer sink for the max-pooling output stream.
// Words arriving on ivalid/din are stored in raster order until a frame of
// 144 (24x24 input) or 16 (8x8 input) words is complete. The frame is then
// held for random-access readout until frame_release frees the buffer.
//
// The buffer-release input is named frame_release because "release" is a
// reserved word in SystemVerilog.

module pool_collector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 144,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              state,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] din,
    output logic              frame_done,
    output logic [AW-1:0]     wr_cnt,
    output logic              overflow,
    input  logic              frame_release,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int SMALL_LEN = 16;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fsm_t;

    fsm_t cur_st;
    fsm_t nxt_st;

    logic [AW-1:0]     wr_cnt_q;
    logic [AW-1:0]     len_q;
    logic [AW-1:0]     cur_len;
    logic              accept;
    logic              first_word;
    logic              last_word;
    logic              rd_ok;
    logic              ovf_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;

    // Frame length for the size-select input: 0 = large map, 1 = small map.
    function automatic logic [AW-1:0] frame_len(input logic sel);
        return sel ? AW'(SMALL_LEN) : AW'(DEPTH);
    endfunction

    // An address is backed by stored data only inside the latched frame.
    function automatic logic addr_in_frame(input logic [AW-1:0] addr,
                                           input logic [AW-1:0] len);
        return addr < len;
    endfunction

    // Write-side qualifiers: acceptance, first/last word of the frame.
    always_comb begin
        accept     = (cur_st == FILL) && ivalid;
        first_word = (wr_cnt_q == '0);
        // On the first word the length is not latched yet, so use the live select.
        cur_len    = first_word ? frame_len(state) : len_q;
        last_word  = accept && (wr_cnt_q == cur_len - AW'(1));
        rd_ok      = (cur_st == FULL) && rd_en;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_st <= FILL;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // FSM next-state: complete on the last word, re-arm on release.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            FILL:    if (last_word)     nxt_st = FULL;
            FULL:    if (frame_release) nxt_st = FILL;
            default:                    nxt_st = FILL;
        endcase
    end

    // FSM outputs: frame_done is decoded from the state register only.
    always_comb begin
        frame_done = (cur_st == FULL);
    end

    // Word counter: counts accepted words, cleared when the held frame is released.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_cnt_q <= '0;
        end else if (accept) begin
            wr_cnt_q <= wr_cnt_q + AW'(1);
        end else if ((cur_st == FULL) && frame_release) begin
            wr_cnt_q <= '0;
        end
    end

    // Frame length latch: sampled once, on the first accepted word of each frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q <= AW'(DEPTH);
        end else if (accept && first_word) begin
            len_q <= frame_len(state);
        end
    end

    // Sticky overflow: set by a word arriving on a held frame; release clears it and wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q <= 1'b0;
        end else if (cur_st == FULL) begin
            if (frame_release) begin
                ovf_q <= 1'b0;
            end else if (ivalid) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Buffer write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_cnt_q] <= din;
        end
    end

    // Read port lookup: addresses beyond the latched frame return zero.
    always_comb begin
        rd_word = '0;
        if (addr_in_frame(rd_addr, len_q)) begin
            rd_word = mem[rd_addr];
        end
    end

    // Read stage p1: registered data and a one-cycle valid pulse per honoured request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_ok;
            if (rd_ok) begin
                rd_data_p1 <= rd_word;
            end
        end
    end

    assign wr_cnt   = wr_cnt_q;
    assign overflow = ovf_q;
    assign rd_data  = rd_data_p1;
    assign rd_valid = vld_p1;

endmodule

// File: tb/tb_pool_collector.sv
// Testbench for pool_collector: directed frames with a read-data scoreboard.
// Reads push their expected data into a queue; a monitor on the falling edge
// pops and compares whenever rd_valid is presented.

module tb_pool_collector;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 144;
    localparam int AW     = 8;

    logic              clk;
    logic              rstn;
    logic              state;
    logic              ivalid;
    logic [DATA_W-1:0] din;
    logic              frame_done;
    logic [AW-1:0]     wr_cnt;
    logic              overflow;
    logic              frame_release;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;

    pool_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .state         (state),
        .ivalid        (ivalid),
        .din           (din),
        .frame_done    (frame_done),
        .wr_cnt        (wr_cnt),
        .overflow      (overflow),
        .frame_release (frame_release),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (rd_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected: got rd_valid=%b data=%0h, expected no read response",
                         rd_valid, rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        ivalid = 1'b1;
        din    = w;
        tick();
        ivalid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_release();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    task automatic drain(input string name);
        tick();
        tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; state = 1'b0; ivalid = 1'b0; din = '0;
        frame_release = 1'b0; rd_en = 1'b0; rd_addr = '0;

        // Reset values
        #12;
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_wr_cnt",     32'(wr_cnt),     0);
        check("rst_overflow",   32'(overflow),   0);
        check("rst_rd_valid",   32'(rd_valid),   0);
        check("rst_rd_data",    32'(rd_data),    0);
        #10 rstn = 1'b1;
        tick();

        // 24x24 frame: words 0..143 back to back
        state = 1'b0;
        for (int i = 0; i < 144; i++) begin
            send(8'(i));
            if (i == 0)   check("f1_wr_cnt_first", 32'(wr_cnt), 1);
            if (i == 142) check("f1_done_early",   32'(frame_done), 0);
        end
        check("f1_frame_done", 32'(frame_done), 1);
        check("f1_wr_cnt",     32'(wr_cnt), 144);
        for (int i = 0; i < 144; i++) do_read(8'(i), 8'(i));
        drain("f1_reads_drained");

        // Overflow: three words on the held frame
        for (int i = 0; i < 3; i++) send(8'h55);
        check("ovf_set",    32'(overflow), 1);
        check("ovf_wr_cnt", 32'(wr_cnt), 144);
        do_read(8'd0, 8'd0);
        do_read(8'd1, 8'd1);
        do_read(8'd143, 8'd143);
        drain("ovf_reads_drained");
        do_release();
        check("rel_overflow",   32'(overflow), 0);
        check("rel_frame_done", 32'(frame_done), 0);
        check("rel_wr_cnt",     32'(wr_cnt), 0);

        // Next word 0xAA lands at address 0
        send(8'hAA);
        for (int i = 1; i < 144; i++) send(8'(i));
        check("f2_frame_done", 32'(frame_done), 1);
        do_read(8'd0, 8'hAA);
        do_read(8'd1, 8'd1);
        drain("f2_reads_drained");

        // release + ivalid + rd_en in the same FULL cycle
        frame_release = 1'b1;
        ivalid  = 1'b1; din = 8'h77;
        rd_en   = 1'b1; rd_addr = 8'd0;
        exp_q.push_back(8'hAA);
        tick();
        frame_release = 1'b0; ivalid = 1'b0; rd_en = 1'b0;
        check("sim_overflow",   32'(overflow), 0);
        check("sim_frame_done", 32'(frame_done), 0);
        check("sim_wr_cnt",     32'(wr_cnt), 0);

        // 8x8 frame: 0xF0..0xFF with an idle cycle between words
        state = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(8'hF0 + 8'(i));
            if (i == 0)  check("f3_wr_cnt_first", 32'(wr_cnt), 1);
            if (i == 14) check("f3_done_early",   32'(frame_done), 0);
            tick();
        end
        check("f3_frame_done", 32'(frame_done), 1);
        check("f3_wr_cnt",     32'(wr_cnt), 16);
        do_read(8'd0, 8'hF0);
        do_read(8'd15, 8'hFF);
        do_read(8'd16, 8'h00);
        do_read(8'd200, 8'h00);
        drain("f3_reads_drained");
        do_release();

        // Size latch: state flips to 1 after word 5, frame still needs 144 words
        state = 1'b0;
        for (int i = 0; i < 144; i++) begin
            send(8'(i) ^ 8'h5A);
            if (i == 5)  state = 1'b1;
            if (i == 15) check("latch_no_early_done", 32'(frame_done), 0);
        end
        check("latch_frame_done", 32'(frame_done), 1);
        check("latch_wr_cnt",     32'(wr_cnt), 144);
        do_read(8'd6,   8'h5C);
        do_read(8'd100, 8'h3E);
        do_read(8'd143, 8'hD5);
        drain("latch_reads_drained");
        do_release();

        // Reset mid-frame
        state = 1'b0;
        for (int i = 0; i < 70; i++) send(8'h11);
        check("mid_wr_cnt_70", 32'(wr_cnt), 70);
        rstn = 1'b0;
        #1;
        check("mid_rst_wr_cnt",     32'(wr_cnt), 0);
        check("mid_rst_frame_done", 32'(frame_done), 0);
        check("mid_rst_rd_valid",   32'(rd_valid), 0);
        #14 rstn = 1'b1;
        tick();

        // Fresh frame with rd_en held high during FILL
        rd_en = 1'b1; rd_addr = 8'd3;
        for (int i = 0; i < 144; i++) begin
            send(8'(255 - i));
            if (i == 0) check("post_rst_wr_cnt_first", 32'(wr_cnt), 1);
        end
        rd_en = 1'b0;
        check("fill_rd_data_held", 32'(rd_data), 0);
        check("f4_frame_done",     32'(frame_done), 1);
        check("f4_wr_cnt",         32'(wr_cnt), 144);
        do_read(8'd0,   8'd255);
        do_read(8'd69,  8'd186);
        do_read(8'd143, 8'd112);
        drain("f4_reads_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
